// File: rtl/bs_pkg.sv
// Shared types and constants for the bs8 shifter and its round-robin front end.
// Holds the FSM encoding, shift directions, datapath widths and the job bundle.
package bs_pkg;

    localparam int BS_W  = 8;
    localparam int AMT_W = 3;
    localparam int ID_W  = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [BS_W-1:0]  data;
        logic [AMT_W-1:0] amt;
        logic             dir;
        logic [ID_W-1:0]  id;
    } job_t;

endpackage

// File: rtl/bs8.sv
// Combinational 8-bit barrel shifter, zero fill in both directions.
// Ports: din operand, sel shift amount, dir (0 left / 1 right), dout result.
module bs8
    import bs_pkg::*;
(
    input  logic [BS_W-1:0]  din,
    input  logic [AMT_W-1:0] sel,
    input  logic             dir,
    output logic [BS_W-1:0]  dout
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            dout = din >> sel;
        end else begin
            dout = din << sel;
        end
    end

endmodule

// File: rtl/bs8_arb.sv
// Round-robin arbiter sharing one bs8 shifter among N_REQ requesters.
// Ports: per-requester valid/ready job channels (data/amt/dir), one valid/ready
// response channel (rsp_data, rsp_id) and busy (high when not idle).
module bs8_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [3*N_REQ-1:0] req_amt,
    input  logic [N_REQ-1:0]   req_dir,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    output logic               busy
);

    import bs_pkg::*;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    job_t            op_q, op_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            found;
    logic [ID_W-1:0] pick;
    logic            grant_en;
    logic            grant;
    logic [7:0]      bs_dout;

    // Search starts one past the last winner so the previous owner
    // goes to the back of the queue.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A grant is only possible from IDLE or while the current response is
    // being accepted; rst_n gating keeps req_ready low during reset.
    assign grant_en = rst_n &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_RESP) && rsp_ready));
    assign grant    = grant_en && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (grant) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = grant ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready = N_REQ'(1) << pick;
        end
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
    end

    always_comb begin
        ptr_d      = ptr_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (grant) begin
            ptr_d     = pick;
            op_d.data = req_data[8*int'(pick) +: 8];
            op_d.amt  = req_amt[3*int'(pick) +: 3];
            op_d.dir  = req_dir[pick];
            op_d.id   = 2'(pick);
        end
        if (state_q == ST_EXEC) begin
            rsp_data_d = bs_dout;
            rsp_id_d   = ID_W'(op_q.id);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= ID_W'(N_REQ - 1);
            op_q       <= '0;
            rsp_data_q <= 8'h00;
            rsp_id_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    bs8 u_bs8 (
        .din  (op_q.data),
        .sel  (op_q.amt),
        .dir  (op_q.dir),
        .dout (bs_dout)
    );

endmodule

// File: tb/tb_bs8_arb.sv
// Directed bench for bs8_arb: vector table for single jobs plus
// hand-written fairness, backpressure and mid-flight reset sequences.
module tb_bs8_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_amt;
    logic [3:0]  req_dir;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bs8_arb #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [1:0] id;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] d,
                           input logic [2:0] a, input logic dr);
        req_data[8*id +: 8] = d;
        req_amt[3*id +: 3]  = a;
        req_dir[id]         = dr;
    endtask

    task automatic run_job(input vec_t v);
        logic [3:0] oh;
        oh = 4'(1) << v.id;
        set_req(int'(v.id), v.data, v.amt, v.dir);
        req_valid = oh;
        rsp_ready = 1'b0;
        #1;
        chk("grant", 32'(req_ready), 32'(oh));
        cyc();
        req_valid = 4'h0;
        #1;
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(req_ready), 32'd0);
        cyc();
        #1;
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(v.exp));
        chk("resp_id", 32'(rsp_id), 32'(v.id));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h96, 3'd3, 1'b0, 2'd0, 8'hB0};
        vecs[1] = '{8'h96, 3'd3, 1'b1, 2'd2, 8'h12};
        vecs[2] = '{8'hA5, 3'd0, 1'b0, 2'd1, 8'hA5};
        vecs[3] = '{8'hFF, 3'd7, 1'b0, 2'd3, 8'h80};
        vecs[4] = '{8'hFF, 3'd7, 1'b1, 2'd0, 8'h01};
        vecs[5] = '{8'h3C, 3'd1, 1'b1, 2'd3, 8'h1E};
        vecs[6] = '{8'h81, 3'd4, 1'b0, 2'd1, 8'h10};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        cyc();
        chk("idle_hold_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
        end

        // fairness from a fresh reset: ptr starts at 3 so req0 wins first
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(8'h11 * (i + 1)), 3'd1, 1'b0);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("rr_first_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            d = 8'(8'h11 * (k % 4 + 1));
            cyc();
            #1;
            chk("rr_exec_valid", 32'(rsp_valid), 32'd0);
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            cyc();
            #1;
            chk("rr_resp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_resp_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_resp_data", 32'(rsp_data), 32'(8'(d << 1)));
            chk("rr_next_grant", 32'(req_ready),
                32'(4'(1) << ((k + 1) % 4)));
        end
        req_valid = 4'h0;
        cyc();
        chk("rr_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // backpressure: req1 result held while req0 waits
        set_req(1, 8'hC3, 3'd2, 1'b1);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = 4'h0;
        cyc();
        set_req(0, 8'h0F, 3'd4, 1'b0);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'h30);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0001);
        chk("bp_release_valid", 32'(rsp_valid), 32'd1);
        cyc();
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        #1;
        chk("bp_exec_valid", 32'(rsp_valid), 32'd0);
        chk("bp_exec_busy", 32'(busy), 32'd1);
        cyc();
        #1;
        chk("bp_r0_valid", 32'(rsp_valid), 32'd1);
        chk("bp_r0_data", 32'(rsp_data), 32'hF0);
        chk("bp_r0_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("bp_idle", 32'(busy), 32'd0);

        // reset while EXEC: job from req2 is dropped
        set_req(2, 8'h5A, 3'd1, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("rx_grant2", 32'(req_ready), 32'b0100);
        cyc();
        set_req(0, 8'h5A, 3'd2, 1'b1);
        set_req(1, 8'h77, 3'd1, 1'b0);
        req_valid = 4'b0011;
        rst_n     = 1'b0;
        #1;
        chk("rx_valid_in_rst", 32'(rsp_valid), 32'd0);
        chk("rx_busy_in_rst", 32'(busy), 32'd0);
        chk("rx_ready_in_rst", 32'(req_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rx_grant0_first", 32'(req_ready), 32'b0001);
        chk("rx_no_stale", 32'(rsp_valid), 32'd0);
        cyc();
        req_valid = 4'h0;
        #1;
        chk("rx_exec_valid", 32'(rsp_valid), 32'd0);
        cyc();
        #1;
        chk("rx_r0_valid", 32'(rsp_valid), 32'd1);
        chk("rx_r0_id", 32'(rsp_id), 32'd0);
        chk("rx_r0_data", 32'(rsp_data), 32'h16);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("rx_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bs8_arb.md
# bs8_arb

Round-robin arbiter and sequencer that shares one `bs8` 8-bit barrel shifter among N requesters. Each requester submits a shift job with valid/ready: data byte, shift amount and direction. The block grants one job at a time, drives the shifter from registered operands, and returns the result with the requester ID on a single valid/ready response channel. It sits between the requesting datapath blocks and the shared shifter.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..4.
- `ID_W`, default 2: width of the requester ID; fixed at 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester job valid.
- `req_ready` out N_REQ: per-requester grant/accept; at most one bit high.
- `req_data` in 8*N_REQ: operand byte; requester i uses bits [8i+7:8i].
- `req_amt` in 3*N_REQ: shift amount 0..7; requester i uses bits [3i+2:3i].
- `req_dir` in N_REQ: 0 = left shift, 1 = logical right shift; zero fill in both directions.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out 8: shifted result.
- `rsp_id` out ID_W: index of the requester that owns `rsp_data`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - The picker chooses the first requester with `req_valid` set, searching from `ptr+1` upward with wrap at N_REQ.
  - `req_ready[sel]` is asserted combinationally in the same cycle.
  - On that handshake, capture data, amt, dir and id into the operand registers, set `ptr` = sel, and go to EXEC.
  - If no requester is valid, stay in IDLE.
- **EXEC**
  - `bs8` is driven from the operand registers: `sel` = amt, `dir` = dir.
  - Its output is registered into `rsp_data`. `rsp_id` takes the captured id.
  - `rsp_valid` is set to 1 and the FSM goes to RESP.
  - No `req_ready` is asserted in EXEC.
- **RESP**
  - `rsp_data` and `rsp_id` are held stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_ready`=1 with a pending `req_valid`, the picker grants in the same cycle: capture the new job and go to EXEC (back-to-back).
  - On `rsp_ready`=1 with no pending request, clear `rsp_valid` and go to IDLE.
  - While `rsp_ready`=0, no `req_ready` is asserted.
- **Shift semantics**
  - Left: `rsp_data` = (data << amt) truncated to 8 bits.
  - Right: `rsp_data` = data >> amt.
  - amt=0 passes data through unchanged.
- **Requester rules**
  - `req_valid` must not depend combinationally on `req_ready`.
  - Once raised, `req_valid` and its operands hold until the handshake.
- **Round-robin fairness:** a continuously valid requester is granted within N_REQ grants.

## Timing
- Reset values:
  - state=IDLE, `ptr`=N_REQ-1, so requester 0 has first priority.
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=8'h00, `rsp_id`=0, `busy`=0.
- Latency:
  - Grant handshake in cycle T gives `rsp_valid`=1 in cycle T+2 (EXEC at T+1, RESP visible from T+2).
- Throughput:
  - One job every 2 cycles with `rsp_ready` held high and requests pending.
  - One job every 3 cycles if the FSM passes through IDLE.
- Simultaneous events:
  - In RESP, response acceptance and a new grant occur in the same cycle.
  - `rsp_valid` stays 1 across the transition to EXEC, then holds the old data for one cycle. The consumer qualifies on the handshake only, so it does not re-consume that data; an implementation may instead drop `rsp_valid` in EXEC.
  - Decided behaviour: drop `rsp_valid` in EXEC. `rsp_valid` is 1 only in RESP.
- Reset mid-operation:
  - Asserting `rst_n`=0 in any state immediately forces all reset values.
  - Any in-flight job is discarded and not replayed.
  - No `req_ready` is asserted while reset is active.

## Structure
- Shared package `bs_pkg` holds:
  - state encoding ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - BS_W=8, AMT_W=3, ID_W=2.
- One sub-module instance: the existing `bs8` barrel shifter, fed only from registered operands, never from request ports.
- The round-robin picker is inline combinational logic, not a separate module.

## Test plan
- Left shift: req0 data=8'h96, amt=3, dir=0 → `rsp_data`=8'hB0, `rsp_id`=0, `rsp_valid` 2 cycles after the handshake.
- Right shift: req2 data=8'h96, amt=3, dir=1 → `rsp_data`=8'h12, `rsp_id`=2.
- Boundaries:
  - data=8'hA5, amt=0 → 8'hA5.
  - data=8'hFF, amt=7, dir=0 → 8'h80.
  - data=8'hFF, amt=7, dir=1 → 8'h01.
- Fairness: all four requesters valid continuously after reset, `rsp_ready`=1 → grant and `rsp_id` order 0,1,2,3,0,1; one response every 2 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_data` and `rsp_id` stable, `req_ready` all 0, `busy`=1; release → handshake, then next grant.
- Reset during EXEC: `rst_n` low for 1 cycle → `rsp_valid`=0 immediately, no response for the dropped job; with req1 and req0 both valid after release, req0 is granted first.
